// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// Integer register file for the riscy32 cores with a per-register busy
// scoreboard and a handshaked debug dump engine.
//
// Parameters:
//   XLEN    data width of each register
//   NREGS   number of architectural registers (power of two, >= 2)
//   BYPASS  1 = same-cycle write data forwarded to matching read ports
//   AW      address width, derived from NREGS
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   we, waddr, wdata     synchronous write port (register 0 ignores writes)
//   ra1/rd1, ra2/rd2     two combinational read ports
//   set_busy, set_addr   mark a destination register as pending
//   busy1, busy2         scoreboard bits of ra1 / ra2
//   dump_req             start a dump (sampled while idle)
//   dump_ready           consumer accepts the current dump beat
//   dump_valid           current dump beat is valid
//   dump_idx, dump_data  register index and contents of the current beat
//   dump_done            one-cycle pulse after the final beat is accepted
//   dump_active          dump engine is not idle
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            set_busy,
  input  logic [AW-1:0]   set_addr,
  output logic            busy1,
  output logic            busy2,
  input  logic            dump_req,
  input  logic            dump_ready,
  output logic            dump_valid,
  output logic [AW-1:0]   dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_done,
  output logic            dump_active
);

  typedef enum logic [1:0] {
    IDLE,
    DUMP,
    DONE
  } state_t;

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   idx;
  logic [AW-1:0]   idx_nxt;
  logic            beat_accept;

  // Register storage. Register 0 is cleared at reset and never written, so
  // it reads as zero even through the dump port which bypasses the read mux.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // Scoreboard. The set is written after the clear so that an issue and a
  // writeback to the same register in one cycle leaves it busy: the new
  // instruction still owns the destination.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (we && waddr != '0) begin
        busy[waddr] <= 1'b0;
      end
      if (set_busy && set_addr != '0) begin
        busy[set_addr] <= 1'b1;
      end
    end
  end

  // Read ports. Forwarding only happens for non-zero addresses, so a write
  // aimed at register 0 can never leak onto a read of register 0.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) begin
      if (BYPASS != 0 && we && waddr == ra1) begin
        rd1 = wdata;
      end else begin
        rd1 = regs[ra1];
      end
    end
    if (ra2 != '0) begin
      if (BYPASS != 0 && we && waddr == ra2) begin
        rd2 = wdata;
      end else begin
        rd2 = regs[ra2];
      end
    end
  end

  assign busy1 = busy[ra1];
  assign busy2 = busy[ra2];

  // Dump engine state register, including the beat index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  assign beat_accept = (state == DUMP) && dump_ready;

  // Dump engine next-state logic. The index holds while the consumer stalls
  // and stays on the last register through DONE, then rewinds in IDLE.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        idx_nxt = '0;
        if (dump_req) begin
          state_nxt = DUMP;
        end
      end
      DUMP: begin
        if (beat_accept) begin
          if (idx == AW'(NREGS - 1)) begin
            state_nxt = DONE;
          end else begin
            idx_nxt = idx + AW'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Dump engine outputs. Beat data comes straight from storage, so a write
  // landing during a dump shows up on any beat presented after that edge.
  always_comb begin
    dump_valid  = (state == DUMP);
    dump_done   = (state == DONE);
    dump_active = (state != IDLE);
    dump_idx    = idx;
    dump_data   = regs[idx];
  end

endmodule
